conv_window_controller: RTL

CONV_WINDOW_CONTROLLER -- requirements
Module: conv_window_controller

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/window_position_counter.sv | 51 +++++
 rtl/conv_window_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared parameter defaults, width helpers and FSM encoding for the conv window controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_IFM_SIZE    = 14;
  localparam int DEF_IFM_DEPTH   = 3;
  localparam int DEF_KERNAL_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Never let a derived width collapse to zero bits.
  function automatic int max1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Pixel address width within one channel.
  function automatic int addr_w(input int ifm_size);
    return max1($clog2(ifm_size * ifm_size));
  endfunction

  // Output pixel index width.
  function automatic int ofm_w(input int ifm_size, input int kernal_size);
    return max1($clog2((ifm_size - kernal_size + 1) * (ifm_size - kernal_size + 1)));
  endfunction

  // Channel select width.
  function automatic int sel_w(input int ifm_depth);
    return max1($clog2(ifm_depth));
  endfunction

  // Row / column counter width.
  function automatic int pos_w(input int ifm_size);
    return max1($clog2(ifm_size));
  endfunction

endpackage

// File: rtl/window_position_counter.sv
// Tracks row/column of the pixel being shifted into the window FIFO and flags legal KxK windows.
// Latency: window_legal is combinational from shift_en and the current position.
// Backpressure: position only advances on shift_en; holds otherwise.
module window_position_counter
  import conv_pkg::*;
#(
  parameter int IFM_SIZE    = DEF_IFM_SIZE,
  parameter int KERNAL_SIZE = DEF_KERNAL_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  output logic window_legal
);

  localparam int PW = pos_w(IFM_SIZE);
  localparam logic [PW-1:0] POS_LAST = PW'(IFM_SIZE - 1);
  localparam logic [PW-1:0] K_LAST   = PW'(KERNAL_SIZE - 1);

  logic [PW-1:0] row_q, row_d;
  logic [PW-1:0] col_q, col_d;

  // Advance raster position per shifted pixel; the last pixel of a channel wraps both to 0.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (shift_en) begin
      if (col_q == POS_LAST) begin
        col_d = '0;
        row_d = (row_q == POS_LAST) ? '0 : row_q + PW'(1);
      end else begin
        col_d = col_q + PW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // A full window exists once at least K-1 rows and K-1 columns precede this pixel in the channel.
  assign window_legal = shift_en && (row_q >= K_LAST) && (col_q >= K_LAST);

endmodule

// File: rtl/conv_window_controller.sv
// Sequences IFM reads channel by channel and marks when the window FIFO taps hold a legal KxK window.
// Latency: fifo_enable one cycle after the read strobe; window_valid one cycle after the shift that completes it.
// Backpressure: ready low stalls new reads and all counters; the read already in flight still shifts.
module conv_window_controller
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IFM_SIZE    = DEF_IFM_SIZE,
  parameter int IFM_DEPTH   = DEF_IFM_DEPTH,
  parameter int KERNAL_SIZE = DEF_KERNAL_SIZE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  ready,
  output logic                                  ifm_read_enable,
  output logic [addr_w(IFM_SIZE)-1:0]           ifm_address,
  output logic [sel_w(IFM_DEPTH)-1:0]           ifm_select,
  output logic                                  fifo_enable,
  output logic                                  window_valid,
  output logic [ofm_w(IFM_SIZE,KERNAL_SIZE)-1:0] ofm_address,
  output logic                                  first_channel,
  output logic                                  busy,
  output logic                                  done
);

  localparam int AW    = addr_w(IFM_SIZE);
  localparam int OW    = ofm_w(IFM_SIZE, KERNAL_SIZE);
  localparam int SW    = sel_w(IFM_DEPTH);
  localparam int N_PIX = IFM_SIZE * IFM_SIZE;
  localparam int N_OUT = (IFM_SIZE - KERNAL_SIZE + 1) * (IFM_SIZE - KERNAL_SIZE + 1);

  localparam logic [AW-1:0] ADDR_LAST = AW'(N_PIX - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(IFM_DEPTH - 1);
  localparam logic [OW-1:0] OFM_LAST  = OW'(N_OUT - 1);

  // Pixel width only matters to the datapath sharing the package; nothing to build here unless it is illegal.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
  end

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          fifo_en_q, fifo_en_d;
  logic [SW-1:0] shift_sel_q, shift_sel_d;
  logic          window_valid_q, window_valid_d;
  logic          first_channel_q, first_channel_d;
  logic [OW-1:0] ofm_q, ofm_d;

  logic rd_en;
  logic last_read;
  logic window_legal;

  assign rd_en     = (state_q == READ) && ready;
  assign last_read = rd_en && (addr_q == ADDR_LAST) && (sel_q == SEL_LAST);

  // Run sequencing: read all channels, one drain cycle for the final shift, then a done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (last_read) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read address / channel walk; wraps into the next channel with no idle cycle.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if (rd_en) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
        sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // Shift-side pipeline: memory data lands one cycle after the read, carrying its channel with it.
  always_comb begin
    fifo_en_d       = rd_en;
    shift_sel_d     = rd_en ? sel_q : shift_sel_q;
    window_valid_d  = window_legal;
    first_channel_d = window_legal && (shift_sel_q == '0);
    ofm_d           = ofm_q;
    if (window_valid_q) begin
      ofm_d = (ofm_q == OFM_LAST) ? '0 : ofm_q + OW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      sel_q           <= '0;
      fifo_en_q       <= 1'b0;
      shift_sel_q     <= '0;
      window_valid_q  <= 1'b0;
      first_channel_q <= 1'b0;
      ofm_q           <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      sel_q           <= sel_d;
      fifo_en_q       <= fifo_en_d;
      shift_sel_q     <= shift_sel_d;
      window_valid_q  <= window_valid_d;
      first_channel_q <= first_channel_d;
      ofm_q           <= ofm_d;
    end
  end

  window_position_counter #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNAL_SIZE (KERNAL_SIZE)
  ) u_pos (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (fifo_en_q),
    .window_legal (window_legal)
  );

  assign ifm_read_enable = rd_en;
  assign ifm_address     = addr_q;
  assign ifm_select      = sel_q;
  assign fifo_enable     = fifo_en_q;
  assign window_valid    = window_valid_q;
  assign ofm_address     = ofm_q;
  assign first_channel   = first_channel_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule
